conv_post: RTL

- Output stage directly downstream of the convolution accumulator. It consumes the final channel sums (s_sum/s_valid) for one output tile.
- Per lane it applies optional ReLU, rounded arithmetic right shift and signed saturation to OW bits.
- It buffers the quantised words in a small FIFO and writes them to the feature-map SRAM at consecutive addresses.
- It reports completion and any dropped data.

---
 rtl/conv_post.sv | 122 ++++++++++++
 1 files changed

// File: rtl/conv_post.sv
// conv_post: quantises accumulator sums (ReLU, rounded shift, saturation) and streams them to SRAM.
module conv_post #(
  parameter int DW = 22,
  parameter int DN = 6,
  parameter int OW = 8,
  parameter int AW = 11,
  parameter int FD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    len,
  input  logic [3:0]       shift,
  input  logic             relu_en,
  input  logic [DW*DN-1:0] s_sum,
  input  logic             s_valid,
  input  logic             w_ready,
  output logic             w_en,
  output logic [AW-1:0]    w_addr,
  output logic [OW*DN-1:0] w_data,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  localparam int PW = $clog2(FD);
  localparam logic signed [DW+1:0] MX = (DW+2)'((1 << (OW-1)) - 1);
  localparam logic signed [DW+1:0] MN = -(DW+2)'(1 << (OW-1));
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_nstate;
  logic [AW-1:0] r_base, r_len, r_in_cnt, r_out_cnt;
  logic [3:0] r_shift;
  logic r_relu, r_qv, r_done, r_ovf, w_done_nx;
  logic [OW*DN-1:0] r_q, w_q;
  logic [OW*DN-1:0] r_mem [FD];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_start, w_in, w_empty, w_full, w_pop, w_push;
  function automatic logic [OW-1:0] quant(input logic [DW-1:0] v, input logic [3:0] sh, input logic re);
    logic signed [DW+1:0] x;
    x = signed'({{2{v[DW-1]}}, v});
    if (re && x < 0) x = '0;
    if (sh != 4'd0) x = x + ((DW+2)'(1) << (sh - 4'd1));
    x = x >>> sh;
    return (x > MX) ? MX[OW-1:0] : (x < MN) ? MN[OW-1:0] : x[OW-1:0];
  endfunction
  for (genvar i = 0; i < DN; i++) begin : g_lane
    assign w_q[i*OW +: OW] = quant(s_sum[i*DW +: DW], r_shift, r_relu);
  end
  assign w_start = start && r_state == IDLE;
  assign w_in    = s_valid && r_state == RUN;
  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == (PW+1)'(FD);
  assign w_en    = !w_empty && w_ready && (r_state == RUN || r_state == DRAIN);
  assign w_pop   = w_en;
  assign w_push  = r_qv && (!w_full || w_pop);
  assign w_addr  = r_base + r_out_cnt;
  assign w_data  = w_empty ? '0 : r_mem[r_rp];
  assign busy    = r_state != IDLE;
  assign done    = r_done;
  assign ovf     = r_ovf;
  always_comb begin
    w_nstate  = r_state;
    w_done_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_nstate  = (start && len != '0) ? RUN : IDLE;
        w_done_nx = start && len == '0;
      end
      RUN: w_nstate = (w_in && r_in_cnt + AW'(1) == r_len) ? DRAIN : RUN;
      DRAIN: begin
        w_nstate  = (w_pop && r_out_cnt + AW'(1) == r_len) ? IDLE : DRAIN;
        w_done_nx = w_pop && r_out_cnt + AW'(1) == r_len;
      end
      default: w_nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base    <= '0;
      r_len     <= '0;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_q       <= '0;
      r_qv      <= 1'b0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= w_done_nx;
      r_qv   <= w_in;
      if (w_in) r_q <= w_q;
      if (w_start) begin
        r_base    <= base;
        r_len     <= len;
        r_shift   <= shift;
        r_relu    <= relu_en;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in) r_in_cnt <= r_in_cnt + AW'(1);
        if (w_pop) r_out_cnt <= r_out_cnt + AW'(1);
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      // sums outside RUN and words arriving at a full, non-draining FIFO are both lost
      if ((s_valid && r_state != RUN) || (r_qv && !w_push)) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_q;
  end
endmodule
